// File: rtl/debug_unit.sv
// debug_unit: UART-driven program loader, run/step gate and state dumper.
// Define DEBUG_MEM_DUMP_EN to append a data memory dump after the snapshot.
module debug_unit #(
    parameter int          PC_BITS          = 32,
    parameter int          INSTRUCTION_BITS = 32,
    parameter int          PROC_BITS        = 32,
    parameter int          DATA_ADDRS_BITS  = 5,
    parameter int          MEM_WORDS        = 32,
    parameter int          DUMP_BITS        = 1024,
    parameter logic [31:0] HALT_INST        = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_start,
    input  logic                       i_tx_done,
    input  logic                       i_halt,
    input  logic [DUMP_BITS-1:0]       i_dump_data,
    input  logic [PROC_BITS-1:0]       i_mem_data,
    output logic                       o_enable,
    output logic                       o_write_inst_mem,
    output logic [PC_BITS-1:0]         o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                       o_debug_read_data,
    output logic [DATA_ADDRS_BITS-1:0] o_debug_read_address
);

    localparam int SIG_BYTES = (DUMP_BITS + 7) / 8;
    localparam int SIG_W     = SIG_BYTES * 8;
    localparam int CNT_W     = $clog2(SIG_BYTES + 1);

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_WRITE,
        RUN,
        STEP,
        SNAP,
        SEND_SIG,
        WAIT_SIG,
        MEM_ADDR,
        MEM_CAPTURE,
        SEND_MEM,
        WAIT_MEM
    } state_t;

    state_t                           state;
    logic [INSTRUCTION_BITS-9:0]      held_bytes;
    logic [1:0]                       load_cnt;
    logic [SIG_W-1:0]                 sig_buf;
    logic [CNT_W-1:0]                 sig_cnt;
    logic [SIG_W-1:0]                 dump_pad;

    // sig_buf holds only the bytes not yet handed to the transmitter
    assign dump_pad = SIG_W'(i_dump_data);

`ifdef DEBUG_MEM_DUMP_EN
    logic [PROC_BITS-1:0] mem_buf;
    logic [1:0]           mem_cnt;
    logic                 unused_cfg;

    assign unused_cfg = (MEM_WORDS > 0);
`else
    logic unused_cfg;

    assign unused_cfg = (MEM_WORDS > 0) ^ (^i_mem_data);
    assign o_debug_read_data    = 1'b0;
    assign o_debug_read_address = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            held_bytes       <= '0;
            load_cnt         <= '0;
            sig_buf          <= '0;
            sig_cnt          <= '0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_enable         <= 1'b0;
            o_write_inst_mem <= 1'b0;
            o_inst_mem_addr  <= '0;
            o_inst_mem_data  <= '0;
`ifdef DEBUG_MEM_DUMP_EN
            mem_buf              <= '0;
            mem_cnt              <= '0;
            o_debug_read_data    <= 1'b0;
            o_debug_read_address <= '0;
`endif
        end else begin
            o_tx_start       <= 1'b0;
            o_write_inst_mem <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            o_inst_mem_addr <= '0;
                            load_cnt        <= '0;
                            state           <= LOAD;
                        end else if (i_rx_data == CMD_RUN) begin
                            state <= RUN;
                        end else if (i_rx_data == CMD_STEP) begin
                            o_enable <= 1'b1;
                            state    <= STEP;
                        end
                    end
                end
                LOAD: begin
                    if (i_rx_valid) begin
                        held_bytes <= {held_bytes[INSTRUCTION_BITS-17:0], i_rx_data};
                        load_cnt   <= load_cnt + 2'd1;
                        if (load_cnt == 2'd3) begin
                            o_inst_mem_data  <= {held_bytes, i_rx_data};
                            o_write_inst_mem <= 1'b1;
                            state            <= LOAD_WRITE;
                        end
                    end
                end
                LOAD_WRITE: begin
                    o_inst_mem_addr <= o_inst_mem_addr + PC_BITS'(1);
                    if (o_inst_mem_data == HALT_INST) begin
                        state <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        o_enable <= 1'b0;
                        state    <= SNAP;
                    end else begin
                        o_enable <= 1'b1;
                    end
                end
                STEP: begin
                    o_enable <= 1'b0;
                    state    <= SNAP;
                end
                SNAP: begin
                    sig_buf    <= dump_pad << 8;
                    sig_cnt    <= '0;
                    o_tx_data  <= dump_pad[SIG_W-1 -: 8];
                    o_tx_start <= 1'b1;
                    state      <= SEND_SIG;
                end
                SEND_SIG: begin
                    state <= WAIT_SIG;
                end
                WAIT_SIG: begin
                    if (i_tx_done) begin
                        if (sig_cnt == CNT_W'(SIG_BYTES - 1)) begin
`ifdef DEBUG_MEM_DUMP_EN
                            o_debug_read_data    <= 1'b1;
                            o_debug_read_address <= '0;
                            state                <= MEM_ADDR;
`else
                            state <= IDLE;
`endif
                        end else begin
                            sig_buf    <= sig_buf << 8;
                            sig_cnt    <= sig_cnt + CNT_W'(1);
                            o_tx_data  <= sig_buf[SIG_W-1 -: 8];
                            o_tx_start <= 1'b1;
                            state      <= SEND_SIG;
                        end
                    end
                end
`ifdef DEBUG_MEM_DUMP_EN
                MEM_ADDR: begin
                    state <= MEM_CAPTURE;
                end
                MEM_CAPTURE: begin
                    mem_buf    <= i_mem_data << 8;
                    mem_cnt    <= '0;
                    o_tx_data  <= i_mem_data[PROC_BITS-1 -: 8];
                    o_tx_start <= 1'b1;
                    state      <= SEND_MEM;
                end
                SEND_MEM: begin
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (i_tx_done) begin
                        if (mem_cnt != 2'd3) begin
                            mem_buf    <= mem_buf << 8;
                            mem_cnt    <= mem_cnt + 2'd1;
                            o_tx_data  <= mem_buf[PROC_BITS-1 -: 8];
                            o_tx_start <= 1'b1;
                            state      <= SEND_MEM;
                        end else if (o_debug_read_address ==
                                     DATA_ADDRS_BITS'(MEM_WORDS - 1)) begin
                            o_debug_read_data    <= 1'b0;
                            o_debug_read_address <= '0;
                            state                <= IDLE;
                        end else begin
                            o_debug_read_address <= o_debug_read_address
                                                    + DATA_ADDRS_BITS'(1);
                            state                <= MEM_ADDR;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller for the pipelined MIPS processor. It receives command bytes from the UART receiver and loads program words into instruction memory. It gates the pipeline `enable` for continuous or single-step execution. After each run or step it streams a snapshot of pipeline and register state, plus optionally data memory, back through the UART transmitter.

## Interface
Parameters:
- `PC_BITS`, 32: instruction memory address width.
- `INSTRUCTION_BITS`, 32: instruction word width; must be 32.
- `PROC_BITS`, 32: data word width; must be 32.
- `DATA_ADDRS_BITS`, 5: data memory address width.
- `MEM_WORDS`, 32: number of data words dumped; must be ≤ 2^`DATA_ADDRS_BITS`.
- `DUMP_BITS`, 1024: width of the concatenated state snapshot (register file and latch buses).
- `HALT_INST`, 32'hFFFF_FFFF: word that terminates loading.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: one-cycle pulse; `i_rx_data` is valid.
- `o_tx_data` out 8: byte to transmit.
- `o_tx_start` out 1: one-cycle pulse requesting transmission of `o_tx_data`.
- `i_tx_done` in 1: one-cycle pulse; the transmitter finished the previous byte.
- `i_halt` in 1: the halt instruction has reached writeback.
- `i_dump_data` in `DUMP_BITS`: live state snapshot.
- `i_mem_data` in 32: data memory read word.
- `o_enable` out 1: pipeline enable.
- `o_write_inst_mem` out 1: instruction memory write strobe.
- `o_inst_mem_addr` out `PC_BITS`: instruction memory write address.
- `o_inst_mem_data` out 32: instruction memory write word.
- `o_debug_read_data` out 1: data memory debug read select.
- `o_debug_read_address` out `DATA_ADDRS_BITS`: data memory debug read address.

## Operation
- Commands are accepted only in IDLE. Byte 0x01 = LOAD, 0x02 = RUN, 0x03 = STEP. All other bytes are dropped.
- LOAD:
  - Collect 4 bytes, MSB first, into the word shift register, then pulse `o_write_inst_mem` for 1 cycle with the current address.
  - Increment the address by 1 per word. The address wraps at 2^`PC_BITS`.
  - If the word equals `HALT_INST`, write it, then return to IDLE.
  - The write address is cleared on entering LOAD.
- RUN: hold `o_enable`=1 every cycle until `i_halt` is sampled 1, then go to SNAP.
  - `o_enable` drops the cycle after `i_halt` is seen.
  - If `i_halt` is already 1 on entry, enable is never asserted.
- STEP: `o_enable`=1 for exactly one cycle, then SNAP.
- SNAP: register `i_dump_data` into the snapshot buffer.
- SEND_SIG: send `ceil(DUMP_BITS/8)` bytes, MSB first. The top byte is zero-padded.
- MEM phase:
  - For each address 0..`MEM_WORDS`-1: drive `o_debug_read_data`=1 and the address, capture `i_mem_data` one cycle later, then send 4 bytes MSB first.
  - `o_debug_read_data` is deasserted on leaving the MEM phase.
- Byte handshake:
  - Pulse `o_tx_start` with stable `o_tx_data`, then wait for `i_tx_done` before the next pulse.
  - `o_tx_data` is held until `i_tx_done`.
  - `i_tx_done` arriving outside a wait state is ignored.
- After the final byte's `i_tx_done`, return to IDLE.
- `i_rx_valid` is ignored outside IDLE and LOAD.
- States: IDLE, LOAD, LOAD_WRITE, RUN, STEP, SNAP, SEND_SIG, WAIT_SIG, MEM_ADDR, MEM_CAPTURE, SEND_MEM, WAIT_MEM.

## Timing
- Reset: state IDLE. Every output is 0: `o_enable`, `o_tx_start`, `o_tx_data`, `o_write_inst_mem`, `o_inst_mem_addr`, `o_inst_mem_data`, `o_debug_read_data`, `o_debug_read_address`. All counters are 0.
- Reset mid-operation aborts immediately; no partial byte or write completes.
- All outputs are registered.
- Write strobe timing: `o_write_inst_mem` is asserted the cycle after the 4th `i_rx_valid` of a word.
- First `o_tx_start` timing: asserted 2 cycles after the last enable cycle (SNAP, then SEND_SIG).
- Memory word latency: 2 cycles from address drive to the first byte start.

## Configuration
- `DEBUG_MEM_DUMP_EN`:
  - Defined: the MEM phase follows SEND_SIG.
  - Undefined: the MEM phase is not compiled. IDLE follows the last snapshot byte; `o_debug_read_data` and `o_debug_read_address` are constant 0.

## Test plan
- LOAD: bytes 01, 20 08 00 05, FF FF FF FF → two writes: addr 0 data 0x20080005, then addr 1 data 0xFFFFFFFF; state back to IDLE.
- STEP with `DUMP_BITS`=16 and `i_dump_data`=0xA55A (macro off) → exactly one `o_enable` cycle; bytes A5, 5A sent, each only after `i_tx_done`.
- RUN with `i_halt` rising after 10 cycles → exactly 10 enable cycles, then the dump starts.
- RUN with `i_halt`=1 on entry → zero enable cycles, dump starts.
- `DEBUG_MEM_DUMP_EN` with `MEM_WORDS`=2, mem[0]=0x11223344, mem[1]=0xDEADBEEF → after the signal bytes, 11 22 33 44 DE AD BE EF are sent.
- `rst` asserted during WAIT_SIG → all outputs 0 next cycle; a following 0x03 starts a fresh step.
